cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//  Shares one LSU-style memory port (lsu -> wb_bus) between two cache requesters:
//  port 0 = instruction cache, port 1 = data cache. Requesters use the cache's
//  refill/writeback handshake (level read/write held until valid).
//  Grants are locked for a full cacheline burst; fair round-robin between bursts.
// PARAMETERS
//  BURST_LEN   8   beats per grant lock; equals N_WORDS_PER_LINE of the caches
//  FIXED_PRIO  0   0: round-robin between bursts; 1: port 0 always wins a tie
// PORTS
//  clk             in   1   clock
//  rstn_i          in   1   asynchronous, active-low reset
//  p0_read_i       in   1   port 0 load request (held until p0_valid_o)
//  p0_write_i      in   1   port 0 store request (held until p0_valid_o)
//  p0_we_i         in   4   port 0 byte enables
//  p0_addr_i       in   32  port 0 word address
//  p0_data_i       in   32  port 0 store data
//  p0_data_o       out  32  port 0 load data, valid with p0_valid_o
//  p0_valid_o      out  1   port 0 beat complete
//  p1_*            --   --  identical set for port 1
//  mem_read_o      out  1   to lsu read_i
//  mem_write_o     out  1   to lsu write_i
//  mem_we_o        out  4   to lsu we_i
//  mem_addr_o      out  32  to lsu addr_i
//  mem_data_o      out  32  to lsu data_i
//  mem_data_i      in   32  from lsu data_o
//  mem_valid_i     in   1   from lsu valid_o (one pulse per completed beat)
// BEHAVIOUR
//  - Reset: state IDLE, owner=0, last_owner=1 (port 0 wins first tie), beat_cnt=0;
//    all outputs 0. Reset mid-burst aborts immediately; outputs 0 asynchronously.
//  - req_k = pk_read_i | pk_write_i. States IDLE, BUSY (owner register 0/1).
//  - IDLE: no mem_* driven. If any req_k, pick winner, next cycle BUSY with
//    owner=winner, beat_cnt=0. Grant latency: 1 cycle from request to mem_* active.
//  - Winner: only one requesting -> that one; both -> FIXED_PRIO ? 0 : ~last_owner.
//  - BUSY: mem_* = owner's inputs, combinational pass-through;
//    mem_read_o = rd & ~wr (write has precedence if both set).
//    Owner receives data_o=mem_data_i, valid_o=mem_valid_i; non-owner data_o=0, valid_o=0.
//  - beat_cnt ($clog2(BURST_LEN)+1 bits) increments on each mem_valid_i in BUSY.
//  - Release when (mem_valid_i && beat_cnt==BURST_LEN-1) or owner's req_k==0:
//    last_owner<=owner, beat_cnt<=0; other port requesting -> stay BUSY, owner flips
//    (zero-bubble switch); else owner still requesting -> stay BUSY, same owner;
//    else -> IDLE.
//  - Cache writeback then refill = 2*BURST_LEN beats: second burst re-arbitrates,
//    so the other port may interleave; each burst is atomic.
//  - Never switch owner between beat issue and mem_valid_i; owner dropping request
//    mid-beat is a requester protocol error; arbiter still releases next cycle.
//  - Non-owner requests are stalled (no valid) with no loss; they must stay held.
// STRUCTURE
//  - cache_pkg: arb_state_t enum {ARB_IDLE, ARB_BUSY}, PORT_I=1'b0, PORT_D=1'b1.
//  - Sub-module rr_arbiter_2: combinational 2-way winner from req[1:0],
//    last_owner, FIXED_PRIO. FSM, counter and muxes live in cache_mem_arbiter.
// TESTING
//  - Single p0 read burst, mem_valid every 2 cycles: 8 beats at p0, p1_valid_o=0,
//    IDLE one cycle after 8th valid.
//  - p0,p1 requesting same cycle after reset: p0 gets 8 beats, p1 then gets 8
//    with no idle cycle between; repeat -> p1 first (round-robin).
//  - FIXED_PRIO=1, both continuously requesting: p0 owns every burst.
//  - p1 write, we=4'hf, addr 0x0000_1040, data 0xDEADBEEF: mem_write_o=1,
//    mem_read_o=0, mem_addr_o/mem_data_o match; p0 read during it stalls.
//  - p0 drops request after 3 beats: return to IDLE (or grant p1) next cycle, beat_cnt=0.
//  - rstn_i low at beat 5: all outputs 0 at once; after reset, p0 wins first tie.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache memory-port arbiter.
// Port 0 is the instruction cache, port 1 is the data cache.
package cache_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter_rr.sv
// Combinational two-way winner selection.
// A tie goes to port 0 under fixed priority, otherwise to the port that did not own last.
module rr_arbiter_2
    import cache_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    output logic       o_any,
    output logic       o_winner
);

    always_comb begin
        o_any    = |i_req;
        o_winner = PORT_I;
        if (i_req == 2'b11) begin
            o_winner = (FIXED_PRIO != 0) ? PORT_I : ~i_last_owner;
        end else if (i_req[1]) begin
            o_winner = PORT_D;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one LSU memory port between the instruction and data caches.
// Each grant is locked for a full line burst; ownership is re-arbitrated between bursts.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int BURST_LEN  = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        p0_read_i,
    input  logic        p0_write_i,
    input  logic [3:0]  p0_we_i,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_data_i,
    output logic [31:0] p0_data_o,
    output logic        p0_valid_o,
    input  logic        p1_read_i,
    input  logic        p1_write_i,
    input  logic [3:0]  p1_we_i,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_data_i,
    output logic [31:0] p1_data_o,
    output logic        p1_valid_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_valid_i
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_t       r_state;
    logic             r_owner;
    logic             r_last_owner;
    logic [CNT_W-1:0] r_beat_cnt;

    logic [1:0] w_req;
    logic       w_busy;
    logic       w_release;
    logic       w_arb_last;
    logic       w_any;
    logic       w_winner;

    assign w_req     = {p1_read_i | p1_write_i, p0_read_i | p0_write_i};
    assign w_busy    = (r_state == ARB_BUSY);
    assign w_release = w_busy && ((mem_valid_i && (r_beat_cnt == LAST_BEAT)) || !w_req[r_owner]);

    // On release the current owner is the one that just owned, so it loses a tie.
    assign w_arb_last = w_busy ? r_owner : r_last_owner;

    rr_arbiter_2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_rr (
        .i_req        (w_req),
        .i_last_owner (w_arb_last),
        .o_any        (w_any),
        .o_winner     (w_winner)
    );

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ARB_IDLE;
            r_owner      <= PORT_I;
            r_last_owner <= PORT_D;
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_state    <= ARB_BUSY;
                        r_owner    <= w_winner;
                        r_beat_cnt <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (w_release) begin
                        r_last_owner <= r_owner;
                        r_beat_cnt   <= '0;
                        if (w_any) begin
                            r_owner <= w_winner;
                        end else begin
                            r_state <= ARB_IDLE;
                        end
                    end else if (mem_valid_i) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_we_o    = '0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        p0_data_o   = '0;
        p0_valid_o  = 1'b0;
        p1_data_o   = '0;
        p1_valid_o  = 1'b0;
        if (w_busy) begin
            if (r_owner == PORT_D) begin
                mem_read_o  = p1_read_i & ~p1_write_i;
                mem_write_o = p1_write_i;
                mem_we_o    = p1_we_i;
                mem_addr_o  = p1_addr_i;
                mem_data_o  = p1_data_i;
                p1_data_o   = mem_data_i;
                p1_valid_o  = mem_valid_i;
            end else begin
                mem_read_o  = p0_read_i & ~p0_write_i;
                mem_write_o = p0_write_i;
                mem_we_o    = p0_we_i;
                mem_addr_o  = p0_addr_i;
                mem_data_o  = p0_data_i;
                p0_data_o   = mem_data_i;
                p0_valid_o  = mem_valid_i;
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: round-robin and fixed-priority instances share stimulus
// and are checked every cycle against a burst-level ownership model.
module tb_cache_mem_arbiter;

    localparam int BL = 8;

    logic clk = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk = ~clk;

    logic        rd [2];
    logic        wr [2];
    logic [3:0]  we [2];
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic        mem_valid_i;
    logic [31:0] mem_data_i;

    logic [31:0] o_pdata [2][2];
    logic        o_pval  [2][2];
    logic        o_mrd   [2];
    logic        o_mwr   [2];
    logic [3:0]  o_mwe   [2];
    logic [31:0] o_maddr [2];
    logic [31:0] o_mdata [2];

    cache_mem_arbiter #(.BURST_LEN(BL), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rstn_i(rstn_i),
        .p0_read_i(rd[0]), .p0_write_i(wr[0]), .p0_we_i(we[0]), .p0_addr_i(addr[0]), .p0_data_i(wdat[0]),
        .p0_data_o(o_pdata[0][0]), .p0_valid_o(o_pval[0][0]),
        .p1_read_i(rd[1]), .p1_write_i(wr[1]), .p1_we_i(we[1]), .p1_addr_i(addr[1]), .p1_data_i(wdat[1]),
        .p1_data_o(o_pdata[0][1]), .p1_valid_o(o_pval[0][1]),
        .mem_read_o(o_mrd[0]), .mem_write_o(o_mwr[0]), .mem_we_o(o_mwe[0]),
        .mem_addr_o(o_maddr[0]), .mem_data_o(o_mdata[0]),
        .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i)
    );

    cache_mem_arbiter #(.BURST_LEN(BL), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rstn_i(rstn_i),
        .p0_read_i(rd[0]), .p0_write_i(wr[0]), .p0_we_i(we[0]), .p0_addr_i(addr[0]), .p0_data_i(wdat[0]),
        .p0_data_o(o_pdata[1][0]), .p0_valid_o(o_pval[1][0]),
        .p1_read_i(rd[1]), .p1_write_i(wr[1]), .p1_we_i(we[1]), .p1_addr_i(addr[1]), .p1_data_i(wdat[1]),
        .p1_data_o(o_pdata[1][1]), .p1_valid_o(o_pval[1][1]),
        .mem_read_o(o_mrd[1]), .mem_write_o(o_mwr[1]), .mem_we_o(o_mwe[1]),
        .mem_addr_o(o_maddr[1]), .mem_data_o(o_mdata[1]),
        .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i)
    );

    int tests = 0;
    int failures = 0;
    int cyc = 0;
    int vp = 0;
    int tick = 0;
    int vcnt [2][2];
    int first_v [2][2];
    int last_v [2][2];

    // Memory stub: one valid pulse every vp cycles, fresh random read data each cycle.
    always @(posedge clk) begin
        #1;
        tick++;
        mem_valid_i = (vp != 0) && ((tick % vp) == 0);
        mem_data_i  = $urandom;
    end

    // Model: who owns the port and how many beats of the current burst have completed.
    bit m_busy [2];
    int m_owner [2];
    int m_last [2];
    int m_cnt [2];

    function automatic int pick(bit r0, bit r1, int last, int fp);
        if (r0 && r1) return (fp != 0) ? 0 : 1 - last;
        return r1 ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] = 1'b0; m_owner[d] = 0; m_last[d] = 1; m_cnt[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit r0, r1, own_req, done;
                r0 = rd[0] | wr[0];
                r1 = rd[1] | wr[1];
                if (!m_busy[d]) begin
                    if (r0 || r1) begin
                        m_busy[d] = 1'b1; m_owner[d] = pick(r0, r1, m_last[d], d); m_cnt[d] = 0;
                    end
                end else begin
                    own_req = (m_owner[d] == 0) ? r0 : r1;
                    done = mem_valid_i && (m_cnt[d] == BL - 1);
                    if (done || !own_req) begin
                        m_last[d] = m_owner[d];
                        m_cnt[d] = 0;
                        if (r0 || r1) m_owner[d] = pick(r0, r1, m_last[d], d);
                        else m_busy[d] = 1'b0;
                    end else if (mem_valid_i) begin
                        m_cnt[d]++;
                    end
                end
            end
        end
    end

    logic [135:0] exp_v, act_v;
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            logic e_rd, e_wr;
            logic [3:0] e_we;
            logic [31:0] e_addr, e_data;
            logic e_pv [2];
            logic [31:0] e_pd [2];
            int o;
            e_rd = 1'b0; e_wr = 1'b0; e_we = '0; e_addr = '0; e_data = '0;
            e_pv[0] = 1'b0; e_pv[1] = 1'b0; e_pd[0] = '0; e_pd[1] = '0;
            if (rstn_i && m_busy[d]) begin
                o = m_owner[d];
                e_wr = wr[o]; e_rd = rd[o] & ~wr[o]; e_we = we[o];
                e_addr = addr[o]; e_data = wdat[o];
                e_pd[o] = mem_data_i; e_pv[o] = mem_valid_i;
            end
            exp_v = {e_rd, e_wr, e_we, e_addr, e_data, e_pv[0], e_pv[1], e_pd[0], e_pd[1]};
            act_v = {o_mrd[d], o_mwr[d], o_mwe[d], o_maddr[d], o_mdata[d],
                     o_pval[d][0], o_pval[d][1], o_pdata[d][0], o_pdata[d][1]};
            tests++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_model dut%0d cyc %0d: got %h expected %h", d, cyc, act_v, exp_v);
            end
            for (int p = 0; p < 2; p++) begin
                if (o_pval[d][p] === 1'b1) begin
                    vcnt[d][p]++;
                    if (first_v[d][p] < 0) first_v[d][p] = cyc;
                    last_v[d][p] = cyc;
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic clr();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                vcnt[d][p] = 0; first_v[d][p] = -1; last_v[d][p] = -1;
            end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_v(int d, int p, int n);
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            k++;
            if (vcnt[d][p] >= n || k >= 400) break;
        end
        #1;
        if (vcnt[d][p] < n) begin
            tests++; failures++;
            $display("FAIL wait_valid dut%0d port%0d: got %0d beats expected %0d", d, p, vcnt[d][p], n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int p = 0; p < 2; p++) begin
            rd[p] = 1'b0; wr[p] = 1'b0; we[p] = '0; addr[p] = '0; wdat[p] = '0;
        end
        mem_valid_i = 1'b0; mem_data_i = '0;
        clr();
        step(3);
        chk("rst_mem_read", {31'd0, o_mrd[0]}, 32'd0);
        chk("rst_mem_addr", o_maddr[0], 32'd0);
        rstn_i = 1'b1;

        // Single p0 burst, valid every other cycle.
        clr(); vp = 2; rd[0] = 1'b1; addr[0] = 32'h0000_0100;
        wait_v(0, 0, BL);
        rd[0] = 1'b0;
        chk("t1_p1_no_valid", vcnt[0][1], 32'd0);
        step(4);
        chk("t1_p0_beats", vcnt[0][0], 32'd8);
        chk("t1_idle_read", {31'd0, o_mrd[0]}, 32'd0);

        // Tie right after reset: p0 first, p1 follows with no bubble.
        rstn_i = 1'b0; step(2); rstn_i = 1'b1;
        clr(); vp = 1; rd[0] = 1'b1; rd[1] = 1'b1; addr[1] = 32'h0000_0200;
        wait_v(0, 0, BL);
        rd[0] = 1'b0;
        wait_v(0, 1, BL);
        rd[1] = 1'b0;
        step(3);
        chk("t2_p0_beats", vcnt[0][0], 32'd8);
        chk("t2_zero_bubble", first_v[0][1] - last_v[0][0], 32'd1);

        // After a p0-only burst, the next tie goes to p1.
        clr(); rd[0] = 1'b1;
        wait_v(0, 0, BL);
        rd[0] = 1'b0;
        step(2);
        clr(); rd[0] = 1'b1; rd[1] = 1'b1;
        wait_v(0, 1, 1);
        chk("t2b_rr_p1_first", vcnt[0][0], 32'd0);
        wait_v(0, 1, BL);
        rd[1] = 1'b0;
        wait_v(0, 0, BL);
        rd[0] = 1'b0;
        step(3);

        // Both continuously requesting: fixed priority never serves p1.
        rstn_i = 1'b0; step(2); rstn_i = 1'b1;
        clr(); vp = 1; rd[0] = 1'b1; rd[1] = 1'b1;
        step(40);
        chk("t3_fp_p1_starved", vcnt[1][1], 32'd0);
        chk("t3_fp_p0_served", (vcnt[1][0] >= 30) ? 32'd1 : 32'd0, 32'd1);
        chk("t3_rr_p1_served", (vcnt[0][1] >= 8) ? 32'd1 : 32'd0, 32'd1);
        rd[0] = 1'b0; rd[1] = 1'b0;
        step(3);

        // p1 write (read also set: write wins), p0 read stalls behind it.
        vp = 0; clr();
        rd[1] = 1'b1; wr[1] = 1'b1; we[1] = 4'hf; addr[1] = 32'h0000_1040; wdat[1] = 32'hDEAD_BEEF;
        step(1);
        rd[0] = 1'b1; addr[0] = 32'h0000_2000;
        step(2);
        chk("t4_mem_write", {31'd0, o_mwr[0]}, 32'd1);
        chk("t4_mem_read", {31'd0, o_mrd[0]}, 32'd0);
        chk("t4_mem_we", {28'd0, o_mwe[0]}, 32'h0000_000f);
        chk("t4_mem_addr", o_maddr[0], 32'h0000_1040);
        chk("t4_mem_data", o_mdata[0], 32'hDEAD_BEEF);
        vp = 3;
        wait_v(0, 1, BL);
        rd[1] = 1'b0; wr[1] = 1'b0;
        wait_v(0, 0, BL);
        rd[0] = 1'b0;
        chk("t4_p1_beats", vcnt[0][1], 32'd8);
        chk("t4_p0_stalled", (first_v[0][0] > last_v[0][1]) ? 32'd1 : 32'd0, 32'd1);
        step(3);

        // p0 abandons its burst after 3 beats; p1 is granted a full fresh burst.
        clr(); vp = 2; rd[0] = 1'b1; addr[0] = 32'h0000_0300;
        wait_v(0, 0, 3);
        rd[0] = 1'b0; rd[1] = 1'b1; addr[1] = 32'h0000_0400;
        step(1);
        chk("t5_p1_granted_addr", o_maddr[0], 32'h0000_0400);
        chk("t5_p1_granted_read", {31'd0, o_mrd[0]}, 32'd1);
        rd[0] = 1'b1;
        wait_v(0, 1, BL);
        rd[1] = 1'b0;
        chk("t5_p0_held_off", vcnt[0][0], 32'd3);
        wait_v(0, 0, 3 + BL);
        rd[0] = 1'b0;
        step(3);

        // Reset mid-burst: outputs clear without a clock edge, then p0 wins the tie.
        clr(); vp = 2; rd[0] = 1'b1; addr[0] = 32'h0000_0500;
        wait_v(0, 0, 5);
        #2;
        rstn_i = 1'b0; rd[1] = 1'b1;
        #1;
        chk("t6_async_read", {31'd0, o_mrd[0]}, 32'd0);
        chk("t6_async_addr", o_maddr[0], 32'd0);
        chk("t6_async_p0_valid", {31'd0, o_pval[0][0]}, 32'd0);
        chk("t6_async_p0_data", o_pdata[0][0], 32'd0);
        step(2);
        rstn_i = 1'b1;
        clr();
        wait_v(0, 0, 1);
        chk("t6_p0_wins_after_reset", vcnt[0][1], 32'd0);
        wait_v(0, 0, BL);
        rd[0] = 1'b0;
        wait_v(0, 1, BL);
        rd[1] = 1'b0;
        step(4);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
